zbt_sram_ctrl: RTL and testbench

Parametrised controller for a ZBT (zero-bus-turnaround) synchronous SRAM, shared by NUM_CLIENTS requesters.
- Arbitrates read/write requests round-robin and registers all SRAM control/address outputs.
- Pipelines write data to the SRAM data phase and captures read data into a tagged in-order response FIFO.
- Read issue is credit-gated, so the response FIFO can never overflow.
- Sits between the decoder's memory-access units and the board SRAM pins.

---
 rtl/zbt_sram_pkg.sv | 16 +
 rtl/zbt_resp_fifo.sv | 69 ++++++
 rtl/zbt_sram_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_zbt_sram_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zbt_sram_pkg.sv
// zbt_sram_pkg
// Shared constants for the ZBT SRAM controller:
//   - op encodings carried down the command pipeline (NOP / RD / WR)
//   - values the SRAM pins take when no command or data phase is active
package zbt_sram_pkg;

  localparam logic [1:0] OP_NOP = 2'd0;
  localparam logic [1:0] OP_RD  = 2'd1;
  localparam logic [1:0] OP_WR  = 2'd2;

  localparam logic IDLE_CE_N  = 1'b1;
  localparam logic IDLE_WE_N  = 1'b1;
  localparam logic IDLE_OE_N  = 1'b0;
  localparam logic IDLE_BUS_T = 1'b1;

endpackage

// File: rtl/zbt_resp_fifo.sv
// zbt_resp_fifo
// In-order response FIFO holding {client id, read data}.
// Ports:
//   i_clk, i_rst_n       clock, asynchronous active-low reset (empties the FIFO)
//   i_enq, i_enq_data    push one entry (caller guarantees free space)
//   i_deq                pop head; ignored while empty
//   o_deq_data           head entry
//   o_empty_n            1 when at least one entry is held
//   o_count              number of entries held
module zbt_resp_fifo
  import zbt_sram_pkg::*;
#(
  parameter  int WIDTH = 33,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_enq,
  input  logic [WIDTH-1:0] i_enq_data,
  input  logic             i_deq,
  output logic [WIDTH-1:0] o_deq_data,
  output logic             o_empty_n,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_deq;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // A pop of an empty FIFO is dropped here so callers need not gate it.
  assign w_deq      = i_deq & (r_count != '0);
  assign o_deq_data = r_mem[r_rptr];
  assign o_empty_n  = (r_count != '0);
  assign o_count    = r_count;

  // Storage: when full, enq writes the head slot, which is safe because
  // a simultaneous deq has already consumed the head value combinationally.
  always_ff @(posedge i_clk) begin
    if (i_enq) begin
      r_mem[r_wptr] <= i_enq_data;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_enq) r_wptr <= ptr_inc(r_wptr);
      if (w_deq) r_rptr <= ptr_inc(r_rptr);
      case ({i_enq, w_deq})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/zbt_sram_ctrl.sv
// zbt_sram_ctrl
// Round-robin, credit-gated controller for a ZBT synchronous SRAM.
// Ports:
//   CLK, RST_N                      clock, asynchronous active-low reset
//   REQ_VALID/WRITE/ADDR/WDATA/BE   flattened per-client requests
//   REQ_RDY                         one-hot grant (combinational)
//   DOUT, DOUT_ID, DOUT_VALID       head of the in-order read response FIFO
//   DOUT_EN                         dequeue head
//   ADDR_O, WE_N_O, WE_BYTES_N_O,
//   CE_N_O, OE_N_O                  registered SRAM control pins
//   CEN_N_O, ADV_LD_N_O             tied low
//   DATA_BUS_O/I, DATA_BUS_T        data pad; T = 1 releases the bus
module zbt_sram_ctrl
  import zbt_sram_pkg::*;
#(
  parameter int ADDR_WIDTH  = 18,
  parameter int BUS_WIDTH   = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_CLIENTS = 2,
  parameter int ID_WIDTH    = 1,
  parameter int RD_LATENCY  = 2,
  parameter int RESP_DEPTH  = 4
) (
  input  logic                              CLK,
  input  logic                              RST_N,
  input  logic [NUM_CLIENTS-1:0]            REQ_VALID,
  input  logic [NUM_CLIENTS-1:0]            REQ_WRITE,
  input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] REQ_ADDR,
  input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] REQ_WDATA,
  input  logic [NUM_CLIENTS*BUS_WIDTH/8-1:0] REQ_BE,
  output logic [NUM_CLIENTS-1:0]            REQ_RDY,
  output logic [DATA_WIDTH-1:0]             DOUT,
  output logic [ID_WIDTH-1:0]               DOUT_ID,
  output logic                              DOUT_VALID,
  input  logic                              DOUT_EN,
  output logic [ADDR_WIDTH-1:0]             ADDR_O,
  output logic                              WE_N_O,
  output logic [BUS_WIDTH/8-1:0]            WE_BYTES_N_O,
  output logic                              CE_N_O,
  output logic                              OE_N_O,
  output logic                              CEN_N_O,
  output logic                              ADV_LD_N_O,
  output logic [BUS_WIDTH-1:0]              DATA_BUS_O,
  input  logic [BUS_WIDTH-1:0]              DATA_BUS_I,
  output logic                              DATA_BUS_T
);

  localparam int BEW = BUS_WIDTH / 8;
  localparam int CW  = $clog2(RESP_DEPTH + 1);
  localparam int PW  = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam int FW  = DATA_WIDTH + ID_WIDTH;

  logic [NUM_CLIENTS-1:0] w_elig;
  logic [NUM_CLIENTS-1:0] w_grant;
  logic [PW-1:0]          w_gidx;
  logic                   w_fire;
  logic                   w_wr_sel;
  logic                   w_rd_fire;
  logic                   w_deq;
  logic                   w_enq;
  logic                   w_wr_next;
  logic                   w_empty_n;
  logic [CW-1:0]          w_fifo_count;
  logic [FW-1:0]          w_fifo_out;

  logic [PW-1:0]          r_ptr;
  logic [CW-1:0]          r_credit;
  logic [1:0]             r_op    [RD_LATENCY+1];
  logic [ID_WIDTH-1:0]    r_id    [RD_LATENCY+1];
  logic [DATA_WIDTH-1:0]  r_wdata [RD_LATENCY];

  // Reads need a free response slot; writes never produce a response.
  assign w_elig = REQ_VALID & (REQ_WRITE | {NUM_CLIENTS{r_credit != '0}});

  // Round-robin pick: first eligible client at or after the pointer.
  always_comb begin
    int unsigned idx;
    logic        found;
    idx     = 0;
    found   = 1'b0;
    w_grant = '0;
    w_gidx  = '0;
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      idx = int'(r_ptr) + k;
      if (idx >= NUM_CLIENTS) idx = idx - NUM_CLIENTS;
      if (!found && w_elig[idx]) begin
        w_grant[idx] = 1'b1;
        w_gidx       = PW'(idx);
        found        = 1'b1;
      end else begin
        found = found;
      end
    end
  end

  // Grants are suppressed while reset is asserted.
  assign REQ_RDY   = w_grant & {NUM_CLIENTS{RST_N}};
  assign w_fire    = |REQ_RDY;
  assign w_wr_sel  = REQ_WRITE[w_gidx];
  assign w_rd_fire = w_fire & ~w_wr_sel;
  assign w_deq     = DOUT_EN & (w_fifo_count != '0);

  // Arbitration pointer and response credits (a dequeue returns its credit next cycle)
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_ptr    <= '0;
      r_credit <= CW'(RESP_DEPTH);
    end else begin
      if (w_fire) r_ptr <= (w_gidx == PW'(NUM_CLIENTS - 1)) ? '0 : w_gidx + PW'(1);
      r_credit <= r_credit - CW'(w_rd_fire) + CW'(w_deq);
    end
  end

  // Command cycle pins: one cycle after the grant
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ADDR_O       <= '0;
      CE_N_O       <= IDLE_CE_N;
      WE_N_O       <= IDLE_WE_N;
      WE_BYTES_N_O <= '1;
    end else if (w_fire) begin
      ADDR_O       <= REQ_ADDR[w_gidx*ADDR_WIDTH +: ADDR_WIDTH];
      CE_N_O       <= 1'b0;
      WE_N_O       <= ~w_wr_sel;
      WE_BYTES_N_O <= w_wr_sel ? ~REQ_BE[w_gidx*BEW +: BEW] : '1;
    end else begin
      CE_N_O       <= IDLE_CE_N;
      WE_N_O       <= IDLE_WE_N;
      WE_BYTES_N_O <= '1;
    end
  end

  // Op pipeline: stage k describes the command issued k+1 cycles ago
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int k = 0; k <= RD_LATENCY; k++) begin
        r_op[k] <= OP_NOP;
        r_id[k] <= '0;
      end
      for (int k = 0; k < RD_LATENCY; k++) r_wdata[k] <= '0;
    end else begin
      r_op[0]    <= w_fire ? (w_wr_sel ? OP_WR : OP_RD) : OP_NOP;
      r_id[0]    <= ID_WIDTH'(w_gidx);
      r_wdata[0] <= REQ_WDATA[w_gidx*DATA_WIDTH +: DATA_WIDTH];
      for (int k = 1; k <= RD_LATENCY; k++) begin
        r_op[k] <= r_op[k-1];
        r_id[k] <= r_id[k-1];
      end
      for (int k = 1; k < RD_LATENCY; k++) r_wdata[k] <= r_wdata[k-1];
    end
  end

  // The data phase pins are loaded one stage early so they are flop outputs
  // exactly during the data phase of the write.
  assign w_wr_next = (r_op[RD_LATENCY-1] == OP_WR);

  // Write data phase: drive the pad, disable SRAM output
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      DATA_BUS_T <= IDLE_BUS_T;
      OE_N_O     <= IDLE_OE_N;
      DATA_BUS_O <= '0;
    end else begin
      DATA_BUS_T <= ~w_wr_next;
      OE_N_O     <= w_wr_next;
      DATA_BUS_O <= w_wr_next ? BUS_WIDTH'(r_wdata[RD_LATENCY-1]) : '0;
    end
  end

  // Read data is on the pad during the last pipeline stage.
  assign w_enq = (r_op[RD_LATENCY] == OP_RD);

  zbt_resp_fifo #(
    .WIDTH (FW),
    .DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .i_clk      (CLK),
    .i_rst_n    (RST_N),
    .i_enq      (w_enq),
    .i_enq_data ({r_id[RD_LATENCY], DATA_BUS_I[DATA_WIDTH-1:0]}),
    .i_deq      (w_deq),
    .o_deq_data (w_fifo_out),
    .o_empty_n  (w_empty_n),
    .o_count    (w_fifo_count)
  );

  assign DOUT       = w_fifo_out[DATA_WIDTH-1:0];
  assign DOUT_ID    = w_fifo_out[DATA_WIDTH +: ID_WIDTH];
  assign DOUT_VALID = w_empty_n;
  assign CEN_N_O    = 1'b0;
  assign ADV_LD_N_O = 1'b0;

endmodule

// File: tb/tb_zbt_sram_ctrl.sv
// tb_zbt_sram_ctrl
// Directed bench for zbt_sram_ctrl with a small behavioural ZBT SRAM model
// (2-cycle data phase, byte-merging writes) on the data pad.
module tb_zbt_sram_ctrl;

  localparam int AW = 18;
  localparam int BW = 32;
  localparam int DW = 32;
  localparam int NC = 2;
  localparam int IW = 1;
  localparam int L  = 2;
  localparam int RD = 4;

  logic              CLK = 1'b0;
  logic              RST_N;
  logic [NC-1:0]     REQ_VALID;
  logic [NC-1:0]     REQ_WRITE;
  logic [NC*AW-1:0]  REQ_ADDR;
  logic [NC*DW-1:0]  REQ_WDATA;
  logic [NC*BW/8-1:0] REQ_BE;
  logic [NC-1:0]     REQ_RDY;
  logic [DW-1:0]     DOUT;
  logic [IW-1:0]     DOUT_ID;
  logic              DOUT_VALID;
  logic              DOUT_EN;
  logic [AW-1:0]     ADDR_O;
  logic              WE_N_O;
  logic [BW/8-1:0]   WE_BYTES_N_O;
  logic              CE_N_O;
  logic              OE_N_O;
  logic              CEN_N_O;
  logic              ADV_LD_N_O;
  logic [BW-1:0]     DATA_BUS_O;
  logic [BW-1:0]     DATA_BUS_I;
  logic              DATA_BUS_T;

  always #5 CLK = ~CLK;

  zbt_sram_ctrl #(
    .ADDR_WIDTH(AW), .BUS_WIDTH(BW), .DATA_WIDTH(DW), .NUM_CLIENTS(NC),
    .ID_WIDTH(IW), .RD_LATENCY(L), .RESP_DEPTH(RD)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .REQ_VALID(REQ_VALID), .REQ_WRITE(REQ_WRITE),
    .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA), .REQ_BE(REQ_BE), .REQ_RDY(REQ_RDY),
    .DOUT(DOUT), .DOUT_ID(DOUT_ID), .DOUT_VALID(DOUT_VALID), .DOUT_EN(DOUT_EN),
    .ADDR_O(ADDR_O), .WE_N_O(WE_N_O), .WE_BYTES_N_O(WE_BYTES_N_O), .CE_N_O(CE_N_O),
    .OE_N_O(OE_N_O), .CEN_N_O(CEN_N_O), .ADV_LD_N_O(ADV_LD_N_O),
    .DATA_BUS_O(DATA_BUS_O), .DATA_BUS_I(DATA_BUS_I), .DATA_BUS_T(DATA_BUS_T)
  );

  // ---------------- SRAM model ----------------
  logic [31:0]   mem   [256];
  logic          sa_v  [L];
  logic          sa_we [L];
  logic [AW-1:0] sa_a  [L];
  logic [3:0]    sa_be [L];

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] ben);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (!ben[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  always @(posedge CLK) begin
    if (!RST_N) begin
      for (int i = 0; i < L; i++) begin
        sa_v[i] <= 1'b0; sa_we[i] <= 1'b0; sa_a[i] <= '0; sa_be[i] <= 4'hF;
      end
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[8'h10] <= 32'hDEADBEEF;
      mem[8'h20] <= 32'hAAAAAAAA;
      mem[8'h30] <= 32'h30303030;
      mem[8'h40] <= 32'h40404040;
      mem[8'h41] <= 32'h41414141;
    end else begin
      if (sa_v[L-1] && sa_we[L-1])
        mem[sa_a[L-1][7:0]] <= merge(mem[sa_a[L-1][7:0]], DATA_BUS_O, sa_be[L-1]);
      sa_v[0] <= !CE_N_O; sa_we[0] <= !WE_N_O; sa_a[0] <= ADDR_O; sa_be[0] <= WE_BYTES_N_O;
      for (int k = 1; k < L; k++) begin
        sa_v[k] <= sa_v[k-1]; sa_we[k] <= sa_we[k-1]; sa_a[k] <= sa_a[k-1]; sa_be[k] <= sa_be[k-1];
      end
    end
  end

  assign DATA_BUS_I = (sa_v[L-1] && !sa_we[L-1]) ? mem[sa_a[L-1][7:0]] : 32'h0;

  // ---------------- checking ----------------
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int c, input logic v, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [3:0] be);
    REQ_VALID[c]          = v;
    REQ_WRITE[c]          = w;
    REQ_ADDR[c*AW +: AW]  = a;
    REQ_WDATA[c*DW +: DW] = d;
    REQ_BE[c*4 +: 4]      = be;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int fires, cnt, stale, gcnt, dcnt;
  logic       g_arr  [32];
  logic       dq_id  [32];
  logic [31:0] dq_d  [32];

  initial begin
    RST_N = 1'b0; REQ_VALID = '0; REQ_WRITE = '0; REQ_ADDR = '0; REQ_WDATA = '0;
    REQ_BE = '0; DOUT_EN = 1'b0;
    set_req(0, 1'b1, 1'b0, 18'h10, 32'h0, 4'hF);

    // 1: reset values
    repeat (3) @(negedge CLK);
    #1;
    chk("rst_ce_n", CE_N_O, 1'b1);
    chk("rst_we_n", WE_N_O, 1'b1);
    chk("rst_bytes", WE_BYTES_N_O, 4'hF);
    chk("rst_addr", ADDR_O, 18'h0);
    chk("rst_bus_t", DATA_BUS_T, 1'b1);
    chk("rst_oe_n", OE_N_O, 1'b0);
    chk("rst_bus_o", DATA_BUS_O, 32'h0);
    chk("rst_dv", DOUT_VALID, 1'b0);
    chk("rst_rdy", REQ_RDY, 2'b00);
    chk("cen_n", CEN_N_O, 1'b0);
    chk("adv_ld_n", ADV_LD_N_O, 1'b0);

    // 2: single read of 0x10, fires in this cycle (t)
    RST_N = 1'b1;
    #1 chk("t2_rdy", REQ_RDY, 2'b01);
    @(negedge CLK); REQ_VALID = '0; #1;
    chk("t2_addr", ADDR_O, 18'h10);
    chk("t2_ce", CE_N_O, 1'b0);
    chk("t2_we", WE_N_O, 1'b1);
    chk("t2_bytes_rd", WE_BYTES_N_O, 4'hF);
    @(negedge CLK); #1;
    chk("t2_idle_ce", CE_N_O, 1'b1);
    chk("t2_dv2", DOUT_VALID, 1'b0);
    @(negedge CLK); #1 chk("t2_dv3", DOUT_VALID, 1'b0);
    @(negedge CLK); #1;
    chk("t2_dv4", DOUT_VALID, 1'b1);
    chk("t2_dout", DOUT, 32'hDEADBEEF);
    chk("t2_id", DOUT_ID, 1'b0);
    DOUT_EN = 1'b1;
    @(negedge CLK); DOUT_EN = 1'b0; #1 chk("t2_deq", DOUT_VALID, 1'b0);

    // 3: partial write then read of 0x20
    @(negedge CLK);
    set_req(0, 1'b1, 1'b1, 18'h20, 32'h12345678, 4'b0011);
    #1 chk("t3_rdy_wr", REQ_RDY, 2'b01);
    @(negedge CLK);
    set_req(0, 1'b1, 1'b0, 18'h20, 32'h0, 4'hF);
    #1;
    chk("t3_rdy_rd", REQ_RDY, 2'b01);
    chk("t3_bytes", WE_BYTES_N_O, 4'b1100);
    chk("t3_we", WE_N_O, 1'b0);
    chk("t3_addr", ADDR_O, 18'h20);
    chk("t3_t1", DATA_BUS_T, 1'b1);
    @(negedge CLK); REQ_VALID = '0; #1;
    chk("t3_rd_we", WE_N_O, 1'b1);
    chk("t3_rd_ce", CE_N_O, 1'b0);
    chk("t3_t2", DATA_BUS_T, 1'b1);
    @(negedge CLK); #1;
    chk("t3_t3", DATA_BUS_T, 1'b0);
    chk("t3_bus_o", DATA_BUS_O, 32'h12345678);
    chk("t3_oe", OE_N_O, 1'b1);
    @(negedge CLK); #1;
    chk("t3_t4", DATA_BUS_T, 1'b1);
    chk("t3_oe4", OE_N_O, 1'b0);
    @(negedge CLK); #1;
    chk("t3_dv", DOUT_VALID, 1'b1);
    chk("t3_dout", DOUT, 32'hAAAA5678);
    DOUT_EN = 1'b1;
    @(negedge CLK); DOUT_EN = 1'b0;

    // 4: credit limit
    set_req(0, 1'b1, 1'b0, 18'h30, 32'h0, 4'h0);
    fires = 0;
    for (int k = 0; k < 10; k++) begin
      #1 if (REQ_VALID[0] && REQ_RDY[0]) fires++;
      @(negedge CLK);
    end
    chk("t4_fires", fires, 4);
    chk("t4_rdy0", REQ_RDY, 2'b00);
    chk("t4_dout", DOUT, 32'h30303030);
    DOUT_EN = 1'b1;
    #1 chk("t4_same_cycle", REQ_RDY, 2'b00);
    @(negedge CLK); DOUT_EN = 1'b0;
    #1 chk("t4_extra", REQ_RDY, 2'b01);
    @(negedge CLK);
    #1 chk("t4_after", REQ_RDY, 2'b00);
    REQ_VALID = '0;
    repeat (6) @(negedge CLK);
    cnt = 0; DOUT_EN = 1'b1;
    for (int k = 0; k < 12; k++) begin
      #1 if (DOUT_VALID) cnt++;
      @(negedge CLK);
    end
    DOUT_EN = 1'b0;
    chk("t4_drain", cnt, 4);

    // 5: both clients read; pointer is at 1 after the client-0 stream
    set_req(0, 1'b1, 1'b0, 18'h40, 32'h0, 4'h0);
    set_req(1, 1'b1, 1'b0, 18'h41, 32'h0, 4'h0);
    DOUT_EN = 1'b1; gcnt = 0; dcnt = 0;
    for (int k = 0; k < 24; k++) begin
      if (k == 16) REQ_VALID = '0;
      #1;
      if (REQ_RDY != 2'b00 && gcnt < 32) begin g_arr[gcnt] = REQ_RDY[1]; gcnt++; end
      if (DOUT_VALID && dcnt < 32) begin dq_id[dcnt] = DOUT_ID; dq_d[dcnt] = DOUT; dcnt++; end
      @(negedge CLK);
    end
    DOUT_EN = 1'b0;
    chk("t5_enough", (gcnt >= 4), 1'b1);
    chk("t5_all_back", dcnt, gcnt);
    for (int k = 0; k < 6 && k < gcnt; k++) begin
      chk($sformatf("t5_grant%0d", k), g_arr[k], (k % 2 == 0) ? 1'b1 : 1'b0);
      chk($sformatf("t5_id%0d", k), dq_id[k], (k % 2 == 0) ? 1'b1 : 1'b0);
      chk($sformatf("t5_data%0d", k), dq_d[k], (k % 2 == 0) ? 32'h41414141 : 32'h40404040);
    end

    // 5b: no credit, client 1 write still granted
    set_req(0, 1'b1, 1'b0, 18'h40, 32'h0, 4'h0);
    fires = 0;
    for (int k = 0; k < 12 && fires < 4; k++) begin
      #1 if (REQ_VALID[0] && REQ_RDY[0]) fires++;
      @(negedge CLK);
    end
    chk("t5b_fires", fires, 4);
    set_req(1, 1'b1, 1'b1, 18'h50, 32'h55, 4'hF);
    #1 chk("t5b_wr_grant", REQ_RDY, 2'b10);
    @(negedge CLK); REQ_VALID[1] = 1'b0;
    #1;
    chk("t5b_rd_stall", REQ_RDY, 2'b00);
    chk("t5b_wr_ce", CE_N_O, 1'b0);
    chk("t5b_wr_we", WE_N_O, 1'b0);
    REQ_VALID = '0;

    // 6: reset with operations in flight
    repeat (6) @(negedge CLK);
    DOUT_EN = 1'b1;
    @(negedge CLK); @(negedge CLK); DOUT_EN = 1'b0;
    set_req(0, 1'b1, 1'b1, 18'h60, 32'hCAFE0001, 4'hF);
    #1 chk("t6_wr", REQ_RDY, 2'b01);
    @(negedge CLK); set_req(0, 1'b1, 1'b0, 18'h10, 32'h0, 4'h0);
    #1 chk("t6_rd1", REQ_RDY, 2'b01);
    @(negedge CLK);
    #1 chk("t6_rd2", REQ_RDY, 2'b01);
    @(negedge CLK);
    #1;
    chk("t6_pre_t", DATA_BUS_T, 1'b0);
    chk("t6_pre_dv", DOUT_VALID, 1'b1);
    RST_N = 1'b0;
    #1;
    chk("t6_rst_t", DATA_BUS_T, 1'b1);
    chk("t6_rst_dv", DOUT_VALID, 1'b0);
    chk("t6_rst_ce", CE_N_O, 1'b1);
    chk("t6_rst_oe", OE_N_O, 1'b0);
    chk("t6_rst_rdy", REQ_RDY, 2'b00);
    REQ_VALID = '0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1; stale = 0;
    for (int k = 0; k < 8; k++) begin
      #1 if (DOUT_VALID) stale++;
      @(negedge CLK);
    end
    chk("t6_no_stale", stale, 0);
    set_req(0, 1'b1, 1'b0, 18'h10, 32'h0, 4'h0);
    fires = 0;
    for (int k = 0; k < 10; k++) begin
      #1 if (REQ_VALID[0] && REQ_RDY[0]) fires++;
      @(negedge CLK);
    end
    REQ_VALID = '0;
    chk("t6_fires", fires, 4);
    chk("t6_dout", DOUT, 32'hDEADBEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
